// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused WIDTH times behind a start/busy/done handshake.
module four_bit_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    count;

    logic             a_i;
    logic             b_i;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        a_i      = a_sr[0];
        b_i      = b_sr[0];
        d        = a_i ^ b_i ^ br;
        br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_next = {d, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            Ovf    <= 1'b0;
            Zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        br     <= Bin;
                        res_sr <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= res_next;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        // br still holds the borrow into the MSB on this edge
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Diff  <= res_next;
                        Bout  <= br_next;
                        Ovf   <= br ^ br_next;
                        Zero  <= (res_next == '0);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/four_bit_serial_subtractor.md
Name: four_bit_serial_subtractor

Overview:
Sequential bit-serial subtractor that computes Diff = A - B - Bin, one bit per clock, LSB first, using a single borrow flip-flop. It is the inverse-direction companion to the team's ripple-carry adder and is meant for area-constrained datapaths where one full-subtractor cell is reused over WIDTH cycles. A start/busy/done handshake lets a controlling FSM launch an operation and collect the result. Status flags report borrow-out, signed overflow and zero.

Parameters:
WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
clk  input  1  single system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when not busy
A  input  WIDTH  minuend; sampled on the accepting edge only
B  input  WIDTH  subtrahend; sampled on the accepting edge only
Bin  input  1  borrow-in; sampled on the accepting edge only
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the result is valid
Diff  output  WIDTH  difference (A - B - Bin) mod 2^WIDTH
Bout  output  1  borrow out of the MSB (1 = unsigned A < B + Bin)
Ovf  output  1  signed two's-complement overflow
Zero  output  1  high when Diff == 0

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy, done, Diff, Bout, Ovf and Zero are all 0; internal shift registers, bit counter and borrow register are cleared. Reset overrides everything, including an operation in progress, which is aborted with no done pulse.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch A, B and Bin; set count=0; go to SHIFT.
  - SHIFT: busy=1. Each edge processes bit i=count:
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d is shifted into the result register from the MSB side; operand registers shift right.
    - count increments. After the edge that processes bit WIDTH-1, go to DONE.
    - Before updating br on bit WIDTH-1, capture br as borrow-into-MSB for the overflow calculation.
  - DONE: a single cycle. Registered outputs are updated on the entry edge. done=1 and busy=0. Behaves as IDLE: start=1 here is accepted (back-to-back), and the next state is SHIFT. Otherwise the next state is IDLE.
- Latency: if start is accepted at edge k, busy=1 after edges k .. k+WIDTH-1. At edge k+WIDTH, Diff, Bout, Ovf and Zero update, done=1 for exactly one cycle, and busy=0. One operation takes WIDTH cycles; throughput is one result per WIDTH+1 cycles with back-to-back start.
- Output flags:
  - Bout = final borrow register value.
  - Ovf = borrow-into-MSB XOR Bout.
  - Zero = (Diff == 0).
- Diff and the flags hold their values until the next DONE entry or reset. They do not change while a new operation is in SHIFT.
- start while busy=1 is ignored. A, B and Bin changes after the accepting edge have no effect.
- start and rst high together: reset wins, and no operation is accepted.

Test Plan:
- Reset, then A=7, B=3, Bin=0, start pulse -> after 4 cycles done=1 for 1 cycle, Diff=4'h4, Bout=0, Ovf=0, Zero=0; busy high exactly 4 cycles.
- A=3, B=7, Bin=0 -> Diff=4'hC, Bout=1, Ovf=0. Then A=0, B=0, Bin=1 -> Diff=4'hF, Bout=1, Ovf=0, Zero=0.
- Signed overflow cases: A=8 (-8), B=1, Bin=0 -> Diff=4'h7, Ovf=1, Bout=0. A=7, B=4'hF (-1) -> Diff=4'h8, Ovf=1, Bout=1.
- A=5, B=5, Bin=0 -> Diff=0, Zero=1, Bout=0. Then, in the done cycle, assert start with A=9, B=2 -> accepted; next done 5 cycles later with Diff=4'h7; the previous outputs hold until then.
- Start A=6, B=1; pulse start with A=0, B=0 during busy -> ignored; result Diff=4'h5, and exactly one done pulse.
- Start A=6, B=1, assert rst on the 2nd busy cycle -> all outputs 0 on the next edge, no done pulse, state IDLE. A fresh start then completes correctly with a 4-cycle latency.
- Exhaustive (WIDTH=4): all 512 combinations of A, B and Bin, back-to-back -> Diff, Bout, Ovf and Zero match a reference model every time.
